// File: rtl/gbe_txfull_monitor.sv
// TX FIFO almost-full / overflow monitor: registered inputs, edge detect, and
// three saturating-or-wrapping counters sharing one clear/enable path.

module gbe_txfull_ctr #(
  parameter int W   = 32,
  parameter bit SAT = 1'b1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         en,
  input  logic         inc,
  output logic [W-1:0] cnt,
  output logic         hit
);
  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    hit   = 1'b0;
    if (clr) begin
      cnt_d = '0;
    end else if (en && inc) begin
      if (&cnt_q) begin
        hit   = 1'b1;
        cnt_d = SAT ? cnt_q : '0;
      end else begin
        cnt_d = cnt_q + W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign cnt = cnt_q;
endmodule

module gbe_txfull_monitor #(
  parameter int CTR_WIDTH = 32,
  parameter int SATURATE  = 1
) (
  input  logic                 user_clk,
  input  logic                 user_rst_n,
  input  logic                 tx_afull,
  input  logic                 tx_overflow,
  input  logic                 ctr_rst,
  input  logic                 ctr_en,
  output logic [CTR_WIDTH-1:0] full_events,
  output logic [CTR_WIDTH-1:0] full_cycles,
  output logic [CTR_WIDTH-1:0] ovf_events,
  output logic                 full_now,
  output logic                 ctr_ovf
);
  localparam int NUM_CTR = 3;

  logic afull_q, afull_d, afull_qq, afull_qd;
  logic ovf_q, ovf_d, rst_q, rst_d, en_q, en_d;
  logic ctr_ovf_q, ctr_ovf_d;

  logic [NUM_CTR-1:0]                evt;
  logic [NUM_CTR-1:0]                hit;
  logic [NUM_CTR-1:0][CTR_WIDTH-1:0] cnt;

  always_comb begin
    afull_d  = tx_afull;
    afull_qd = afull_q;
    ovf_d    = tx_overflow;
    rst_d    = ctr_rst;
    en_d     = ctr_en;
  end

  always_ff @(posedge user_clk or negedge user_rst_n) begin
    if (!user_rst_n) begin
      afull_q  <= 1'b0;
      afull_qq <= 1'b0;
      ovf_q    <= 1'b0;
      rst_q    <= 1'b0;
      en_q     <= 1'b0;
    end else begin
      afull_q  <= afull_d;
      afull_qq <= afull_qd;
      ovf_q    <= ovf_d;
      rst_q    <= rst_d;
      en_q     <= en_d;
    end
  end

  // afull_qq tracks through clear and disable, so an episode spanning
  // either is never counted as a fresh rise afterwards.
  assign evt[0] = afull_q & ~afull_qq;
  assign evt[1] = afull_q;
  assign evt[2] = ovf_q;

  for (genvar i = 0; i < NUM_CTR; i++) begin : g_ctr
    gbe_txfull_ctr #(
      .W   (CTR_WIDTH),
      .SAT (SATURATE != 0)
    ) u_ctr (
      .clk   (user_clk),
      .rst_n (user_rst_n),
      .clr   (rst_q),
      .en    (en_q),
      .inc   (evt[i]),
      .cnt   (cnt[i]),
      .hit   (hit[i])
    );
  end

  always_comb begin
    ctr_ovf_d = rst_q ? 1'b0 : (ctr_ovf_q | (|hit));
  end

  always_ff @(posedge user_clk or negedge user_rst_n) begin
    if (!user_rst_n) ctr_ovf_q <= 1'b0;
    else             ctr_ovf_q <= ctr_ovf_d;
  end

  assign full_events = cnt[0];
  assign full_cycles = cnt[1];
  assign ovf_events  = cnt[2];
  assign full_now    = afull_q;
  assign ctr_ovf     = ctr_ovf_q;
endmodule

// File: tb/tb_gbe_txfull_monitor.sv
// Bench for gbe_txfull_monitor: one wide saturating instance plus 4-bit
// saturating and wrapping instances, checked against a sample-history model.

module tb_gbe_txfull_monitor;
  logic clk = 1'b0;
  logic rst_n, afull, ovf, crst, cen;
  logic cmp_on = 1'b0;

  logic [31:0] fe_m, fc_m, oe_m;
  logic [3:0]  fe_s, fc_s, oe_s, fe_w, fc_w, oe_w;
  logic        fn_m, fn_s, fn_w, co_m, co_s, co_w;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  gbe_txfull_monitor #(.CTR_WIDTH(32), .SATURATE(1)) dut_m (
    .user_clk(clk), .user_rst_n(rst_n), .tx_afull(afull), .tx_overflow(ovf),
    .ctr_rst(crst), .ctr_en(cen), .full_events(fe_m), .full_cycles(fc_m),
    .ovf_events(oe_m), .full_now(fn_m), .ctr_ovf(co_m));

  gbe_txfull_monitor #(.CTR_WIDTH(4), .SATURATE(1)) dut_s (
    .user_clk(clk), .user_rst_n(rst_n), .tx_afull(afull), .tx_overflow(ovf),
    .ctr_rst(crst), .ctr_en(cen), .full_events(fe_s), .full_cycles(fc_s),
    .ovf_events(oe_s), .full_now(fn_s), .ctr_ovf(co_s));

  gbe_txfull_monitor #(.CTR_WIDTH(4), .SATURATE(0)) dut_w (
    .user_clk(clk), .user_rst_n(rst_n), .tx_afull(afull), .tx_overflow(ovf),
    .ctr_rst(crst), .ctr_en(cen), .full_events(fe_w), .full_cycles(fc_w),
    .ovf_events(oe_w), .full_now(fn_w), .ctr_ovf(co_w));

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d at t=%0t", nm, act, exp, $time);
    end
  endtask

  // Model: history of input samples, one per edge since reset. The update
  // applied at edge n uses sample n-1 (and sample n-2 for the rise test).
  // Counts are unbounded true counts since the last clear.
  typedef struct {bit a; bit o; bit r; bit e;} samp_t;
  samp_t  hist[$];
  longint tc_fe = 0, tc_fc = 0, tc_ov = 0;
  samp_t  u;
  bit     pa;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist.delete();
      tc_fe = 0; tc_fc = 0; tc_ov = 0;
    end else begin
      hist.push_back('{a: afull, o: ovf, r: crst, e: cen});
      if (hist.size() >= 2) begin
        u  = hist[hist.size()-2];
        pa = (hist.size() >= 3) ? hist[hist.size()-3].a : 1'b0;
        if (u.r) begin
          tc_fe = 0; tc_fc = 0; tc_ov = 0;
        end else if (u.e) begin
          tc_fe += longint'(u.a & ~pa);
          tc_fc += longint'(u.a);
          tc_ov += longint'(u.o);
        end
      end
      while (hist.size() > 3) void'(hist.pop_front());
    end
  end

  function automatic longint ecnt(input longint tc, input int w, input bit sat);
    longint mx = (longint'(1) << w) - 1;
    if (tc <= mx) return tc;
    return sat ? mx : (tc % (mx + 1));
  endfunction

  function automatic longint eovf(input int w);
    longint mx = (longint'(1) << w) - 1;
    return longint'((tc_fe > mx) || (tc_fc > mx) || (tc_ov > mx));
  endfunction

  function automatic longint efn();
    return (hist.size() > 0) ? longint'(hist[hist.size()-1].a) : 0;
  endfunction

  always @(negedge clk) begin
    if (cmp_on) begin
      chk("m_full_events", fe_m, ecnt(tc_fe, 32, 1));
      chk("m_full_cycles", fc_m, ecnt(tc_fc, 32, 1));
      chk("m_ovf_events",  oe_m, ecnt(tc_ov, 32, 1));
      chk("m_full_now",    fn_m, efn());
      chk("m_ctr_ovf",     co_m, eovf(32));
      chk("s_full_events", fe_s, ecnt(tc_fe, 4, 1));
      chk("s_full_cycles", fc_s, ecnt(tc_fc, 4, 1));
      chk("s_ovf_events",  oe_s, ecnt(tc_ov, 4, 1));
      chk("s_full_now",    fn_s, efn());
      chk("s_ctr_ovf",     co_s, eovf(4));
      chk("w_full_events", fe_w, ecnt(tc_fe, 4, 0));
      chk("w_full_cycles", fc_w, ecnt(tc_fc, 4, 0));
      chk("w_ovf_events",  oe_w, ecnt(tc_ov, 4, 0));
      chk("w_full_now",    fn_w, efn());
      chk("w_ctr_ovf",     co_w, eovf(4));
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b1; afull = 1'b0; ovf = 1'b0; crst = 1'b0; cen = 1'b1;
    #2 rst_n = 1'b0;
    cyc(2);
    cmp_on = 1'b1;
    rst_n  = 1'b1;
    cyc(10);
    chk("lit_reset_fe", fe_m, 0);
    chk("lit_reset_fc", fc_m, 0);
    chk("lit_reset_oe", oe_m, 0);
    chk("lit_reset_fn", fn_m, 0);
    chk("lit_reset_co", co_m, 0);

    // three 3-cycle almost-full episodes
    for (int p = 0; p < 3; p++) begin
      afull = 1'b1;
      cyc(1);
      if (p == 0) begin
        chk("lit_lat_fn_k", fn_m, 1);
        chk("lit_lat_fe_k", fe_m, 0);
      end
      cyc(1);
      if (p == 0) begin
        chk("lit_lat_fe_k1", fe_m, 1);
        chk("lit_lat_fc_k1", fc_m, 1);
      end
      cyc(1);
      afull = 1'b0;
      cyc(3);
    end
    chk("lit_full_events3", fe_m, 3);
    chk("lit_full_cycles9", fc_m, 9);

    // overflow for 5 cycles, disabled for the last 2
    ovf = 1'b1;
    cyc(3);
    cen = 1'b0;
    cyc(2);
    ovf = 1'b0;
    cyc(3);
    chk("lit_ovf_en_gated", oe_m, 3);
    cen = 1'b1;

    // one-cycle software clear
    crst = 1'b1;
    cyc(1);
    crst = 1'b0;
    cyc(1);
    chk("lit_clr_fe", fe_m, 0);
    chk("lit_clr_fc", fc_m, 0);
    chk("lit_clr_oe", oe_m, 0);
    chk("lit_clr_co", co_m, 0);

    // clear coincident with a rise, episode continues past release
    cyc(2);
    crst = 1'b1; afull = 1'b1;
    cyc(1);
    crst = 1'b0;
    cyc(4);
    afull = 1'b0;
    cyc(3);
    chk("lit_clr_rise_fe", fe_m, 0);
    chk("lit_clr_rise_fc", fc_m, 4);

    // 20 overflow cycles: saturate vs wrap at 4 bits
    ovf = 1'b1;
    cyc(20);
    ovf = 1'b0;
    cyc(3);
    chk("lit_sat_oe", oe_s, 15);
    chk("lit_sat_co", co_s, 1);
    chk("lit_wrap_oe", oe_w, 4);
    chk("lit_wrap_co", co_w, 1);
    chk("lit_wide_oe", oe_m, 20);
    chk("lit_wide_co", co_m, 0);

    // asynchronous reset between edges
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("lit_async_m_oe", oe_m, 0);
    chk("lit_async_m_fc", fc_m, 0);
    chk("lit_async_s_oe", oe_s, 0);
    chk("lit_async_s_co", co_s, 0);
    chk("lit_async_w_co", co_w, 0);

    // release with almost-full already high counts one event
    afull = 1'b1;
    cyc(2);
    rst_n = 1'b1;
    cyc(4);
    chk("lit_rel_high_fe", fe_m, 1);
    afull = 1'b0;
    cyc(3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
